// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types and constants for the dual-lane ID/EX issue stage.
//   REG_AW_DEFAULT / CNT_W_DEFAULT : default register-address and counter widths
//   state_t                        : issue FSM state (RUN, SPLIT)
//   action_t                       : what the stage does this cycle (one per priority rule)
//   lane1_ctrl_t / lane2_ctrl_t    : per-lane control bundles held in ID/EX
//   LANE1_BUBBLE / LANE2_BUBBLE    : control values that make a lane a no-op
package id_ex_pkg;

  localparam int REG_AW_DEFAULT = 3;
  localparam int CNT_W_DEFAULT  = 16;

  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    ACT_FLUSH  = 3'd0,  // kill both lanes, return to RUN
    ACT_FREEZE = 3'd1,  // downstream stall: hold everything
    ACT_IDLE   = 3'd2,  // nothing to issue
    ACT_LU     = 3'd3,  // load-use bubble
    ACT_SPLIT  = 3'd4,  // issue lane 1, defer lane 2
    ACT_BOTH   = 3'd5,  // issue the whole bundle
    ACT_LANE2  = 3'd6   // issue the deferred lane 2
  } action_t;

  typedef struct packed {
    logic alusrcb;
    logic regwrite;
    logic memread;
  } lane1_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
  } lane2_ctrl_t;

  localparam lane1_ctrl_t LANE1_BUBBLE = '{alusrcb: 1'b0, regwrite: 1'b0, memread: 1'b0};
  localparam lane2_ctrl_t LANE2_BUBBLE = '{regwrite: 1'b0, memwrite: 1'b0};

endpackage

// File: rtl/id_ex_issue_stage_if.sv
// id_ex_issue_stage_if: decode-side bundle, ID/EX register outputs and the
// IF/ID hold line of the issue stage.
//   master : decode / EX side (drives id_*, observes ex_* and if_id_hold)
//   slave  : the issue stage (consumes id_*, drives ex_* and if_id_hold)
// Handshake: id_valid qualifies the id_* bundle; the producer must keep the
// same bundle on id_* for every cycle in which if_id_hold is 1, and may
// change it only after a cycle with if_id_hold = 0. ex_valid_1/ex_valid_2
// qualify each lane of the registered ex_* fields.
interface id_ex_issue_stage_if #(
  parameter int REG_AW = 3
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rm_1, id_rd_11, id_rd_12, id_rd_1;
  logic              id_alusrcb_1, id_regwrite_1, id_memread_1;
  logic [REG_AW-1:0] id_rm_2, id_rn_2, id_rd_2;
  logic              id_regwrite_2, id_memwrite_2;

  logic              ex_valid_1, ex_valid_2;
  logic [REG_AW-1:0] ex_rm_1, ex_rd_11, ex_rd_12, ex_rd_1;
  logic              ex_alusrcb_1, ex_regwrite_1, ex_memread_1;
  logic [REG_AW-1:0] ex_rm_2, ex_rn_2, ex_rd_2;
  logic              ex_regwrite_2, ex_memwrite_2;

  logic              if_id_hold;

  modport master (
    output id_valid, id_rm_1, id_rd_11, id_rd_12, id_rd_1,
           id_alusrcb_1, id_regwrite_1, id_memread_1,
           id_rm_2, id_rn_2, id_rd_2, id_regwrite_2, id_memwrite_2,
    input  ex_valid_1, ex_valid_2, ex_rm_1, ex_rd_11, ex_rd_12, ex_rd_1,
           ex_alusrcb_1, ex_regwrite_1, ex_memread_1,
           ex_rm_2, ex_rn_2, ex_rd_2, ex_regwrite_2, ex_memwrite_2,
           if_id_hold
  );

  modport slave (
    input  id_valid, id_rm_1, id_rd_11, id_rd_12, id_rd_1,
           id_alusrcb_1, id_regwrite_1, id_memread_1,
           id_rm_2, id_rn_2, id_rd_2, id_regwrite_2, id_memwrite_2,
    output ex_valid_1, ex_valid_2, ex_rm_1, ex_rd_11, ex_rd_12, ex_rd_1,
           ex_alusrcb_1, ex_regwrite_1, ex_memread_1,
           ex_rm_2, ex_rn_2, ex_rd_2, ex_regwrite_2, ex_memwrite_2,
           if_id_hold
  );

endinterface

// File: rtl/id_ex_hazard_detect.sv
// id_ex_hazard_detect: purely combinational hazard detection.
//   ex_valid_1, ex_memread_1, ex_rd_1 : lane 1 currently in EX (possible load)
//   id_*                              : bundle presented by decode
//   load_use_1 / load_use_2           : the EX load writes a source used by lane 1 / lane 2
//   intra_dep                         : lane 2 reads what lane 1 of the same bundle writes
// Register 0 is never a hazard: a zero destination never matches.
module id_ex_hazard_detect #(
  parameter int REG_AW = 3
) (
  input  logic              ex_valid_1,
  input  logic              ex_memread_1,
  input  logic [REG_AW-1:0] ex_rd_1,
  input  logic [REG_AW-1:0] id_rm_1,
  input  logic [REG_AW-1:0] id_rd_11,
  input  logic [REG_AW-1:0] id_rd_12,
  input  logic [REG_AW-1:0] id_rd_1,
  input  logic              id_alusrcb_1,
  input  logic              id_regwrite_1,
  input  logic [REG_AW-1:0] id_rm_2,
  input  logic [REG_AW-1:0] id_rn_2,
  input  logic [REG_AW-1:0] id_rd_2,
  input  logic              id_memwrite_2,
  output logic              load_use_1,
  output logic              load_use_2,
  output logic              intra_dep
);

  function automatic logic hit(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  logic [REG_AW-1:0] src_b_1;
  logic              ex_load;

  // Lane-1 operand B comes from one of two fields depending on ALUSrcB.
  assign src_b_1 = id_alusrcb_1 ? id_rd_12 : id_rd_11;
  assign ex_load = ex_valid_1 && ex_memread_1;

  assign load_use_1 = ex_load && (hit(ex_rd_1, id_rm_1) || hit(ex_rd_1, src_b_1));

  // Lane 2 reads rd_2 only as store data.
  assign load_use_2 = ex_load && (hit(ex_rd_1, id_rm_2) || hit(ex_rd_1, id_rn_2) ||
                                  (id_memwrite_2 && hit(ex_rd_1, id_rd_2)));

  assign intra_dep = id_regwrite_1 && (hit(id_rd_1, id_rm_2) || hit(id_rd_1, id_rn_2) ||
                                       (id_memwrite_2 && hit(id_rd_1, id_rd_2)));

endmodule

// File: rtl/id_ex_issue_stage.sv
// id_ex_issue_stage: dual-lane ID/EX pipeline register with load-use and
// intra-bundle hazard control, upstream of the forwarding unit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : branch redirect, kills the bundle in decode
//   ext_stall    : downstream memory stall, freezes the stage
//   bus (slave)  : id_* bundle in, registered ex_* fields and if_id_hold out
//   state        : current FSM state (RUN / SPLIT) for observation
//   lu_stall_cnt, split_cnt : saturating event counters, present only when
//                  ID_EX_PERF_CNT_EN is defined
// While in SPLIT the decode bundle is held (if_id_hold was 1), so lane 2 is
// re-read from id_* rather than buffered locally.
module id_ex_issue_stage
  import id_ex_pkg::*;
#(
`ifdef ID_EX_PERF_CNT_EN
  parameter int CNT_W  = CNT_W_DEFAULT,
`endif
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 ext_stall,
  id_ex_issue_stage_if.slave   bus,
`ifdef ID_EX_PERF_CNT_EN
  output logic [CNT_W-1:0]     lu_stall_cnt,
  output logic [CNT_W-1:0]     split_cnt,
`endif
  output state_t               state
);

  logic        load_use_1, load_use_2, intra_dep;
  action_t     act;
  state_t      state_nxt;
  logic        issue_1, issue_2;
  lane1_ctrl_t id_ctrl_1, ex_ctrl_1;
  lane2_ctrl_t id_ctrl_2, ex_ctrl_2;
  logic        ex_valid_1, ex_valid_2;
  logic [REG_AW-1:0] ex_rm_1, ex_rd_11, ex_rd_12, ex_rd_1;
  logic [REG_AW-1:0] ex_rm_2, ex_rn_2, ex_rd_2;

  id_ex_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_1    (ex_valid_1),
    .ex_memread_1  (ex_ctrl_1.memread),
    .ex_rd_1       (ex_rd_1),
    .id_rm_1       (bus.id_rm_1),
    .id_rd_11      (bus.id_rd_11),
    .id_rd_12      (bus.id_rd_12),
    .id_rd_1       (bus.id_rd_1),
    .id_alusrcb_1  (bus.id_alusrcb_1),
    .id_regwrite_1 (bus.id_regwrite_1),
    .id_rm_2       (bus.id_rm_2),
    .id_rn_2       (bus.id_rn_2),
    .id_rd_2       (bus.id_rd_2),
    .id_memwrite_2 (bus.id_memwrite_2),
    .load_use_1    (load_use_1),
    .load_use_2    (load_use_2),
    .intra_dep     (intra_dep)
  );

  assign id_ctrl_1.alusrcb  = bus.id_alusrcb_1;
  assign id_ctrl_1.regwrite = bus.id_regwrite_1;
  assign id_ctrl_1.memread  = bus.id_memread_1;
  assign id_ctrl_2.regwrite = bus.id_regwrite_2;
  assign id_ctrl_2.memwrite = bus.id_memwrite_2;

  // Priority decode. In SPLIT lane 1 has already issued, so only lane 2's
  // load-use matters and id_valid is ignored (the bundle is being held).
  always_comb begin
    act = ACT_BOTH;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (ext_stall) begin
      act = ACT_FREEZE;
    end else if (state == RUN) begin
      if (!bus.id_valid)                 act = ACT_IDLE;
      else if (load_use_1 || load_use_2) act = ACT_LU;
      else if (intra_dep)                act = ACT_SPLIT;
      else                               act = ACT_BOTH;
    end else begin
      if (load_use_2) act = ACT_LU;
      else            act = ACT_LANE2;
    end
  end

  always_comb begin
    state_nxt = state;
    if (act == ACT_SPLIT)                          state_nxt = SPLIT;
    else if (act == ACT_FLUSH || act == ACT_LANE2) state_nxt = RUN;
  end

  assign issue_1 = (act == ACT_BOTH) || (act == ACT_SPLIT);
  assign issue_2 = (act == ACT_BOTH) || (act == ACT_LANE2);

  // Gated by rst_n so decode is never held while the stage is in reset.
  assign bus.if_id_hold = rst_n && ((act == ACT_FREEZE) || (act == ACT_LU) ||
                                    (act == ACT_SPLIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      ex_valid_1 <= 1'b0;
      ex_valid_2 <= 1'b0;
      ex_ctrl_1  <= LANE1_BUBBLE;
      ex_ctrl_2  <= LANE2_BUBBLE;
      ex_rm_1    <= '0;
      ex_rd_11   <= '0;
      ex_rd_12   <= '0;
      ex_rd_1    <= '0;
      ex_rm_2    <= '0;
      ex_rn_2    <= '0;
      ex_rd_2    <= '0;
    end else if (act != ACT_FREEZE) begin
      state      <= state_nxt;
      ex_valid_1 <= issue_1;
      ex_valid_2 <= issue_2;
      ex_ctrl_1  <= issue_1 ? id_ctrl_1 : LANE1_BUBBLE;
      ex_ctrl_2  <= issue_2 ? id_ctrl_2 : LANE2_BUBBLE;
      // Addresses of a bubbled lane are don't-care, so they load unconditionally.
      ex_rm_1    <= bus.id_rm_1;
      ex_rd_11   <= bus.id_rd_11;
      ex_rd_12   <= bus.id_rd_12;
      ex_rd_1    <= bus.id_rd_1;
      ex_rm_2    <= bus.id_rm_2;
      ex_rn_2    <= bus.id_rn_2;
      ex_rd_2    <= bus.id_rd_2;
    end
  end

  assign bus.ex_valid_1    = ex_valid_1;
  assign bus.ex_valid_2    = ex_valid_2;
  assign bus.ex_alusrcb_1  = ex_ctrl_1.alusrcb;
  assign bus.ex_regwrite_1 = ex_ctrl_1.regwrite;
  assign bus.ex_memread_1  = ex_ctrl_1.memread;
  assign bus.ex_regwrite_2 = ex_ctrl_2.regwrite;
  assign bus.ex_memwrite_2 = ex_ctrl_2.memwrite;
  assign bus.ex_rm_1       = ex_rm_1;
  assign bus.ex_rd_11      = ex_rd_11;
  assign bus.ex_rd_12      = ex_rd_12;
  assign bus.ex_rd_1       = ex_rd_1;
  assign bus.ex_rm_2       = ex_rm_2;
  assign bus.ex_rn_2       = ex_rn_2;
  assign bus.ex_rd_2       = ex_rd_2;

`ifdef ID_EX_PERF_CNT_EN
  // Flush and freeze never select ACT_LU / ACT_SPLIT, so stalled cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt <= '0;
      split_cnt    <= '0;
    end else begin
      if (act == ACT_LU && lu_stall_cnt != '1)  lu_stall_cnt <= lu_stall_cnt + 1'b1;
      if (act == ACT_SPLIT && split_cnt != '1)  split_cnt    <= split_cnt + 1'b1;
    end
  end
`endif

endmodule
